// File: rtl/tx_dump_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : tx_dump_fifo                                                      |
// | Desc   : Queues register-dump words from the core and hands them one at a |
// |          time to the UART transmitter; flags words lost to a full queue.  |
// |          Define TX_DUMP_FIFO_STATS_EN to add drop_cnt / max_count.         |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tx_dump_fifo #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             tx_ready,
  output logic             tx_isNew,
  output logic [WIDTH-1:0] tx_message,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
`ifdef TX_DUMP_FIFO_STATS_EN
  ,
  output logic [7:0]       drop_cnt,
  output logic [CNT_W-1:0] max_count
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       guard_q, guard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             tx_isnew_q, tx_isnew_d;
  logic [WIDTH-1:0] tx_message_q, tx_message_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic pop;
  logic push;
  logic drop;

  // A pop frees a slot on the same edge, so a push into a full queue still lands.
  assign pop  = (state_q == IDLE) && !empty_q && tx_ready;
  assign push = in_valid && (!full_q || pop);
  assign drop = in_valid && full_q && !pop;

  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tx_message_d = tx_message_q;

    case (state_q)
      IDLE: begin
        if (pop) state_d = SEND;
      end
      SEND: begin
        state_d = WAIT_BUSY;
        guard_d = 2'd0;
      end
      WAIT_BUSY: begin
        // A transmitter that never drops ready is assumed to have taken the word.
        if (!tx_ready)            state_d = WAIT_DONE;
        else if (guard_q == 2'd3) state_d = IDLE;
        else                      guard_d = guard_q + 2'd1;
      end
      WAIT_DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      tx_message_d = mem_q[rd_ptr_q];
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d     = (count_d == FULL_CNT);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | drop;
    tx_isnew_d = (state_d == SEND);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      guard_q      <= 2'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      tx_isnew_q   <= 1'b0;
      tx_message_q <= '0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      tx_isnew_q   <= tx_isnew_d;
      tx_message_q <= tx_message_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= in_data;
  end

  assign tx_isNew   = tx_isnew_q;
  assign tx_message = tx_message_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;

`ifdef TX_DUMP_FIFO_STATS_EN
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] max_count_q, max_count_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q  <= 8'd0;
      max_count_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      max_count_q <= max_count_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign max_count = max_count_q;
`else
  // Statistics are not built; the sticky overflow flag is the only drop indication.
`endif

endmodule

`default_nettype wire
